func_sweep_ctrl: RTL and testbench
==================================

// Module: func_sweep_ctrl
// PURPOSE
//  Frequency-sweep scheduler for the DDS function generators (triangle/sine/square).
//  Drives F_word, P_word and the generator enable so that the generator's frequency steps
//  from f_start to f_stop. Each frequency value is held for a programmable dwell time.
//  Sits between the key/UART configuration logic and one Function_Gent_* instance.
// PARAMETERS
//  FW  8   frequency/phase word width; matches the generator F_word/P_word.
//  DW  16  dwell counter width, in clk cycles.
// PORTS
//  clk        in   1   system clock; all logic is on posedge.
//  rst_n      in   1   asynchronous reset, active low.
//  start      in   1   single-cycle pulse; begins a sweep when idle.
//  stop       in   1   single-cycle pulse; aborts a sweep in any state.
//  cont       in   1   1 = repeat the sweep forever; 0 = run a single sweep.
//  f_start    in   FW  first frequency word.
//  f_stop     in   FW  last frequency word; may be below f_start, giving a down-sweep.
//  f_step     in   FW  step magnitude; 0 is treated as 1.
//  dwell      in   DW  clk cycles per frequency value; 0 is treated as 1.
//  p_word_in  in   FW  phase offset passed through to the generator.
//  F_word     out  FW  to the generator F_word.
//  P_word     out  FW  to the generator P_word.
//  gen_en     out  1   to the generator enable (triang_en or equivalent).
//  busy       out  1   high while in RUN.
//  done       out  1   one-cycle pulse when a single sweep completes.
// BEHAVIOUR
//  - Reset values: F_word=0, P_word=0, gen_en=0, busy=0, done=0, state=IDLE, dwell count=0.
//  - All outputs are registered. No combinational path from any input to any output.
//  - FSM states are IDLE, RUN and DONE.
//  - IDLE, start=1 and stop=0:
//    - latch cont, f_start, f_stop, f_step_eff, dwell_eff and p_word_in;
//    - dir = (f_stop < f_start) ? down : up;
//    - on the next edge: F_word=f_start, P_word=p_word_in, gen_en=1, busy=1, state=RUN.
//  - RUN: the dwell counter increments every clk. When cnt == dwell_eff-1:
//    - F_word != f_stop: F_word takes the next value and cnt returns to 0.
//      Up: next = min(F_word+step, f_stop), computed at FW+1 bits so there is no wrap.
//      Down: next = max(F_word-step, f_stop), with a signed borrow check so there is no wrap.
//    - F_word == f_stop and cont=1: F_word = f_start, cnt = 0.
//    - F_word == f_stop and cont=0: state = DONE.
//  - DONE lasts exactly one cycle with done=1, gen_en=0 and busy=0, then goes to IDLE.
//    F_word holds f_stop.
//  - stop=1 in RUN or DONE: on the next edge state=IDLE, gen_en=0, busy=0 and done=0.
//    F_word and P_word are held. No done pulse is produced.
//  - stop and start asserted in the same cycle: stop wins and the block stays or goes IDLE.
//  - start while busy is ignored. Config inputs are only sampled on an accepted start.
//  - f_start == f_stop: F_word is held for one dwell period, then DONE (or it repeats if cont=1).
//  - Every frequency value, including the first and the last, is presented for exactly
//    dwell_eff cycles.
//  - rst_n falling at any time clears state asynchronously to the reset values. Any sweep in
//    progress is lost.
// STRUCTURE
//  - func_gen_pkg holds the state enum (IDLE, RUN, DONE), the FW/DW defaults and the
//    saturate_step() helper (up/down clamp).
//  - One sub-module, func_dwell_timer: a DW-bit counter with clr, en and a `last` output
//    that flags cnt == dwell_eff-1.
//  - The top level holds the FSM, the config latch and the F_word stepping datapath.
// TESTING
//  1. f_start=10, f_stop=40, f_step=10, dwell=3, cont=0.
//     F_word is 10,10,10,20,20,20,30,30,30,40,40,40, then a 1-cycle done pulse and gen_en=0.
//  2. f_start=200, f_stop=250, f_step=30.
//     F_word sequence is 200, 230, 250 (clamped, no wrap past 255).
//  3. Down-sweep f_start=50, f_stop=5, f_step=20.
//     F_word sequence is 50, 30, 10, 5. f_step=0 steps by 1.
//  4. cont=1, f_start=1, f_stop=3, f_step=1, dwell=1.
//     F_word is 1,2,3,1,2,3,... with no done pulse. stop gives gen_en=0 and busy=0 on the next
//     edge, with F_word held.
//  5. start and stop in the same cycle while IDLE: the block stays IDLE.
//     start mid-sweep with new f_stop=99: ignored, and the sweep finishes at the latched f_stop.
//  6. Assert rst_n low during RUN: all outputs are 0 immediately.
//     After release, start restarts cleanly from f_start.

Source files
------------

// File: rtl/func_gen_pkg.sv
// Shared types, default widths and the clamped-step helper for the frequency-sweep controller.
// The helper works at 32 bits, so any frequency word width up to 32 fits.
package func_gen_pkg;

    localparam int unsigned FwDefault = 8;
    localparam int unsigned DwDefault = 16;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    // One step of cur toward lim, clamped at lim. One extra bit on the sum and on the
    // difference catches overflow and borrow, so the result never wraps.
    function automatic logic [31:0] saturate_step(input logic [31:0] cur,
                                                  input logic [31:0] step,
                                                  input logic [31:0] lim,
                                                  input logic        down);
        logic [32:0] sum;
        logic [32:0] diff;
        logic [31:0] res;
        sum  = {1'b0, cur} + {1'b0, step};
        diff = {1'b0, cur} - {1'b0, step};
        if (down) begin
            res = (diff[32] || (diff[31:0] < lim)) ? lim : diff[31:0];
        end else begin
            res = (sum > {1'b0, lim}) ? lim : sum[31:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/func_dwell_timer.sv
// Dwell counter: counts clock cycles and flags the final cycle of each dwell period.
// The counter wraps to zero on its own after the final cycle.
module func_dwell_timer
    import func_gen_pkg::*;
#(
    parameter int unsigned DW = DwDefault
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr_i,
    input  logic          en_i,
    input  logic [DW-1:0] dwell_eff_i,
    output logic          last_o
);

    logic [DW-1:0] cnt_q, cnt_d;

    assign last_o = (cnt_q == (dwell_eff_i - DW'(1)));

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = last_o ? '0 : cnt_q + DW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/func_sweep_ctrl.sv
// Frequency-sweep scheduler: steps a DDS frequency word from f_start to f_stop, holding each
// value for a programmable number of cycles. Every output comes straight from a register.
module func_sweep_ctrl
    import func_gen_pkg::*;
#(
    parameter int unsigned FW = FwDefault,
    parameter int unsigned DW = DwDefault
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          stop,
    input  logic          cont,
    input  logic [FW-1:0] f_start,
    input  logic [FW-1:0] f_stop,
    input  logic [FW-1:0] f_step,
    input  logic [DW-1:0] dwell,
    input  logic [FW-1:0] p_word_in,
    output logic [FW-1:0] F_word,
    output logic [FW-1:0] P_word,
    output logic          gen_en,
    output logic          busy,
    output logic          done
);

    state_e        state_q;
    logic          cont_q;
    logic          down_q;
    logic [FW-1:0] f_start_q, f_stop_q, f_step_q;
    logic [DW-1:0] dwell_q;
    logic [FW-1:0] f_word_q, p_word_q;
    logic          gen_en_q, busy_q, done_q;

    logic          accept;
    logic          timer_last;
    logic [FW-1:0] f_next;

    assign accept = (state_q == StIdle) && start && !stop;
    assign f_next = FW'(saturate_step(32'(f_word_q), 32'(f_step_q), 32'(f_stop_q), down_q));

    func_dwell_timer #(
        .DW (DW)
    ) u_dwell_timer (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr_i       (accept || stop),
        .en_i        (state_q == StRun),
        .dwell_eff_i (dwell_q),
        .last_o      (timer_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cont_q    <= 1'b0;
            down_q    <= 1'b0;
            f_start_q <= '0;
            f_stop_q  <= '0;
            f_step_q  <= '0;
            dwell_q   <= '0;
            f_word_q  <= '0;
            p_word_q  <= '0;
            gen_en_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    done_q <= 1'b0;
                    if (accept) begin
                        cont_q    <= cont;
                        down_q    <= (f_stop < f_start);
                        f_start_q <= f_start;
                        f_stop_q  <= f_stop;
                        f_step_q  <= (f_step == '0) ? FW'(1) : f_step;
                        dwell_q   <= (dwell == '0) ? DW'(1) : dwell;
                        f_word_q  <= f_start;
                        p_word_q  <= p_word_in;
                        gen_en_q  <= 1'b1;
                        busy_q    <= 1'b1;
                        state_q   <= StRun;
                    end
                end
                StRun: begin
                    if (stop) begin
                        gen_en_q <= 1'b0;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b0;
                        state_q  <= StIdle;
                    end else if (timer_last) begin
                        if (f_word_q != f_stop_q) begin
                            f_word_q <= f_next;
                        end else if (cont_q) begin
                            f_word_q <= f_start_q;
                        end else begin
                            gen_en_q <= 1'b0;
                            busy_q   <= 1'b0;
                            done_q   <= 1'b1;
                            state_q  <= StDone;
                        end
                    end
                end
                StDone: begin
                    // Single-cycle pulse; a stop here lands in the same place.
                    done_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    gen_en_q <= 1'b0;
                    busy_q   <= 1'b0;
                    done_q   <= 1'b0;
                    state_q  <= StIdle;
                end
            endcase
        end
    end

    assign F_word = f_word_q;
    assign P_word = p_word_q;
    assign gen_en = gen_en_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: tb/tb_func_sweep_ctrl.sv
// Bench for func_sweep_ctrl: a sequence-list model checked every cycle, plus literal
// expectations for the directed sweeps.
module tb_func_sweep_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start, stop, cont;
    logic [7:0]  f_start, f_stop, f_step, p_word_in;
    logic [15:0] dwell;
    logic [7:0]  F_word, P_word;
    logic        gen_en, busy, done;

    int total = 0;
    int bad   = 0;

    func_sweep_ctrl #(
        .FW (8),
        .DW (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .stop      (stop),
        .cont      (cont),
        .f_start   (f_start),
        .f_stop    (f_stop),
        .f_step    (f_step),
        .dwell     (dwell),
        .p_word_in (p_word_in),
        .F_word    (F_word),
        .P_word    (P_word),
        .gen_en    (gen_en),
        .busy      (busy),
        .done      (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: the sweep is the list of distinct frequency values; cycle t of a sweep shows
    // entry t/dwell, and the sweep ends after size*dwell cycles.
    int m_seq[$];
    int m_dw   = 1;
    bit m_cont = 1'b0;
    int m_t    = 0;
    bit m_act  = 1'b0;
    bit m_done = 1'b0;
    int m_f    = 0;
    int m_p    = 0;

    function automatic void build_seq(input int fs, input int fe, input int st);
        int f;
        int s;
        s = (st == 0) ? 1 : st;
        m_seq.delete();
        f = fs;
        m_seq.push_back(f);
        while (f != fe) begin
            if (fe > fs) f = (f + s > fe) ? fe : f + s;
            else         f = (f - s < fe) ? fe : f - s;
            m_seq.push_back(f);
        end
    endfunction

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_act = 0; m_done = 0; m_f = 0; m_p = 0; m_t = 0;
            end else if (stop) begin
                m_act = 0; m_done = 0;
            end else if (m_done) begin
                m_done = 0;
            end else if (!m_act) begin
                if (start) begin
                    build_seq(int'(f_start), int'(f_stop), int'(f_step));
                    m_dw   = (dwell == 0) ? 1 : int'(dwell);
                    m_cont = cont;
                    m_t    = 0;
                    m_act  = 1;
                    m_f    = m_seq[0];
                    m_p    = int'(p_word_in);
                end
            end else begin
                m_t++;
                if (m_t == m_seq.size() * m_dw) begin
                    if (m_cont) m_t = 0;
                    else begin m_act = 0; m_done = 1; end
                end
                if (m_act) m_f = m_seq[m_t / m_dw];
            end
        end
    end

    always @(negedge clk) begin
        check("cyc_F_word", 32'(F_word), 32'(m_f));
        check("cyc_P_word", 32'(P_word), 32'(m_p));
        check("cyc_gen_en", 32'(gen_en), 32'(m_act));
        check("cyc_busy",   32'(busy),   32'(m_act));
        check("cyc_done",   32'(done),   32'(m_done));
    end

    int   cap_f[64];
    logic cap_d[64];
    logic cap_g[64];

    task automatic capture(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            cap_f[i] = int'(F_word);
            cap_d[i] = done;
            cap_g[i] = gen_en;
        end
    endtask

    task automatic set_cfg(input int fs, input int fe, input int st, input int dw,
                           input bit c, input int pw);
        f_start   = 8'(fs);
        f_stop    = 8'(fe);
        f_step    = 8'(st);
        dwell     = 16'(dw);
        cont      = c;
        p_word_in = 8'(pw);
    endtask

    task automatic pulse_start();
        @(posedge clk); #2 start = 1'b1;
        @(posedge clk); #2 start = 1'b0;
    endtask

    task automatic wait_idle(input int bound);
        int k = 0;
        while ((busy || done) && k < bound) begin
            @(negedge clk);
            k++;
        end
        check("idle_timeout", 32'(busy || done), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; stop = 1'b0;
        set_cfg(0, 0, 0, 0, 1'b0, 0);
        #12;
        check("rst_F_word", 32'(F_word), 32'd0);
        check("rst_P_word", 32'(P_word), 32'd0);
        check("rst_gen_en", 32'(gen_en), 32'd0);
        check("rst_busy",   32'(busy),   32'd0);
        check("rst_done",   32'(done),   32'd0);
        #10 rst_n = 1'b1;

        // 1: basic up-sweep, 3 cycles per value
        set_cfg(10, 40, 10, 3, 1'b0, 8'h5A);
        pulse_start();
        capture(13);
        for (int i = 0; i < 12; i++) begin
            check("t1_F_seq", 32'(cap_f[i]), 32'(10 + 10 * (i / 3)));
            check("t1_gen_on", 32'(cap_g[i]), 32'd1);
        end
        check("t1_done_pulse", 32'(cap_d[12]), 32'd1);
        check("t1_gen_off",    32'(cap_g[12]), 32'd0);
        check("t1_F_hold",     32'(cap_f[12]), 32'd40);
        check("t1_P_word",     32'(P_word),    32'h5A);
        wait_idle(64);

        // 2: up-sweep clamped below the 8-bit wrap
        set_cfg(200, 250, 30, 2, 1'b0, 3);
        pulse_start();
        check("t2_model_len", 32'(m_seq.size()), 32'd3);
        check("t2_model_2",   32'(m_seq[1]), 32'd230);
        capture(7);
        check("t2_F0", 32'(cap_f[0]), 32'd200);
        check("t2_F1", 32'(cap_f[2]), 32'd230);
        check("t2_F2", 32'(cap_f[4]), 32'd250);
        check("t2_F2b", 32'(cap_f[5]), 32'd250);
        check("t2_done", 32'(cap_d[6]), 32'd1);
        wait_idle(64);

        // 3: down-sweep clamped at f_stop
        set_cfg(50, 5, 20, 1, 1'b0, 0);
        pulse_start();
        check("t3_model_len", 32'(m_seq.size()), 32'd4);
        capture(5);
        check("t3_F0", 32'(cap_f[0]), 32'd50);
        check("t3_F1", 32'(cap_f[1]), 32'd30);
        check("t3_F2", 32'(cap_f[2]), 32'd10);
        check("t3_F3", 32'(cap_f[3]), 32'd5);
        check("t3_done", 32'(cap_d[4]), 32'd1);
        wait_idle(64);

        // 3b: zero step and zero dwell both behave as 1
        set_cfg(5, 8, 0, 0, 1'b0, 0);
        pulse_start();
        capture(5);
        for (int i = 0; i < 4; i++) check("t3b_F_seq", 32'(cap_f[i]), 32'(5 + i));
        check("t3b_done", 32'(cap_d[4]), 32'd1);
        wait_idle(64);

        // 3c: f_start == f_stop holds for one dwell period
        set_cfg(7, 7, 4, 2, 1'b0, 0);
        pulse_start();
        capture(3);
        check("t3c_F0", 32'(cap_f[0]), 32'd7);
        check("t3c_F1", 32'(cap_f[1]), 32'd7);
        check("t3c_done0", 32'(cap_d[1]), 32'd0);
        check("t3c_done", 32'(cap_d[2]), 32'd1);
        wait_idle(64);

        // 4: continuous sweep, then stop
        set_cfg(1, 3, 1, 1, 1'b1, 9);
        pulse_start();
        capture(9);
        for (int i = 0; i < 9; i++) begin
            check("t4_F_seq", 32'(cap_f[i]), 32'(1 + (i % 3)));
            check("t4_no_done", 32'(cap_d[i]), 32'd0);
        end
        stop = 1'b1;
        @(posedge clk); #2 stop = 1'b0;
        @(negedge clk);
        check("t4_stop_gen",  32'(gen_en), 32'd0);
        check("t4_stop_busy", 32'(busy),   32'd0);
        check("t4_stop_done", 32'(done),   32'd0);
        check("t4_stop_F",    32'(F_word), 32'd3);
        check("t4_stop_P",    32'(P_word), 32'd9);
        @(negedge clk);

        // 5: start+stop together while idle, then start mid-sweep is ignored
        set_cfg(0, 20, 10, 2, 1'b0, 0);
        @(posedge clk); #2 begin start = 1'b1; stop = 1'b1; end
        @(posedge clk); #2 begin start = 1'b0; stop = 1'b0; end
        @(negedge clk);
        check("t5_same_busy", 32'(busy),   32'd0);
        check("t5_same_gen",  32'(gen_en), 32'd0);
        pulse_start();
        capture(2);
        start  = 1'b1;
        f_stop = 8'd99;
        @(posedge clk); #2 start = 1'b0;
        capture(5);
        check("t5_F_a", 32'(cap_f[0]), 32'd10);
        check("t5_F_b", 32'(cap_f[2]), 32'd20);
        check("t5_done", 32'(cap_d[4]), 32'd1);
        check("t5_F_end", 32'(cap_f[4]), 32'd20);
        wait_idle(64);

        // 6: asynchronous reset mid-sweep, then a clean restart
        set_cfg(10, 40, 10, 3, 1'b0, 4);
        pulse_start();
        capture(4);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_F",    32'(F_word), 32'd0);
        check("t6_rst_P",    32'(P_word), 32'd0);
        check("t6_rst_gen",  32'(gen_en), 32'd0);
        check("t6_rst_busy", 32'(busy),   32'd0);
        check("t6_rst_done", 32'(done),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        pulse_start();
        capture(4);
        check("t6_restart_F",    32'(cap_f[0]), 32'd10);
        check("t6_restart_F3",   32'(cap_f[3]), 32'd20);
        check("t6_restart_busy", 32'(busy),     32'd1);
        wait_idle(64);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
